control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high. The ports SHALL be:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- ir  in  32  IR register contents; opcode is ir[31:27]
- con  in  1  CON_FF branch-condition result
- stop  in  1  halt request
- run  out  1  processor running indicator
- PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout  out  1 each  bus-source selects, at most one active per cycle
- MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, InIn, OutIn, ZIn, CONIn  out  1 each  register load enables
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls
- read, write  out  1 each  memory strobes
- add, subtract, multiply, divide, andSignal, orSignal, shrSignal, ShlSignal, RorSignal, RolSignal, NegSignal, NotSignal  out  1 each  one-hot ALU operation

Function
REQ-002 The block SHALL be an FSM with states RST, T0–T7 and HALT; all outputs SHALL be combinational decodes of state and ir[31:27].
REQ-003 Fetch SHALL run as follows:
- T0: PCout, MARIn, IncPC
- T1: read, MDRIn
- T2: MDRout, IRIn
REQ-004 Opcode encodings SHALL be:
- ld=0, ldi=1, st=2
- add=3, sub=4, and=5, or=6, shr=7, shl=8, ror=9, rol=10
- addi=11, andi=12, ori=13, mul=14, div=15, neg=16, not=17
- br=18, jr=19, jal=20, in=21, out=22, mfhi=23, mflo=24, nop=25, halt=26
- Codes 27–31 SHALL execute as nop.
REQ-005 R-type ops (3–10) SHALL run:
- T3: Grb, Rout, YIn
- T4: Grc, Rout, ALU op, ZIn
- T5: Zlowout, Gra, Rin
REQ-006 Immediate ops (11–13) SHALL match REQ-005, except that T4 uses Cout instead of Grc/Rout.
REQ-007 mul/div SHALL run:
- T3: Gra, Rout, YIn
- T4: Grb, Rout, op, ZIn
- T5: Zlowout, LoIn
- T6: Zhighout, HiIn
REQ-008 ld SHALL run:
- T3: Grb, BAout, YIn
- T4: Cout, add, ZIn
- T5: Zlowout, MARIn
- T6: read, MDRIn
- T7: MDRout, Gra, Rin
REQ-009 ldi SHALL run T3–T4 as for ld, then T5: Zlowout, Gra, Rin.
REQ-010 st SHALL run T3–T5 as for ld, then:
- T6: Gra, Rout, MDRIn, read=0
- T7: write
REQ-011 br SHALL run:
- T3: Gra, Rout, CONIn
- T4: PCout, YIn
- T5: Cout, add, ZIn
- T6: Zlowout, PCIn only if con=1; otherwise no outputs active
REQ-012 neg/not SHALL run:
- T3: Grb, Rout, op, ZIn
- T4: Zlowout, Gra, Rin
REQ-013 Single-step instructions SHALL run:
- jr: T3 Gra, Rout, PCIn
- in: T3 In_Portout, Gra, Rin
- out: T3 Gra, Rout, OutIn
- mfhi: T3 HIout, Gra, Rin
- mflo: T3 LOout, Gra, Rin
- nop: T3 with no outputs active
REQ-014 jal SHALL run:
- T3: PCout, Grb, Rin
- T4: Gra, Rout, PCIn
REQ-015 From an instruction's final step, the FSM SHALL go to T0, or to HALT if stop was sampled high during that instruction.
REQ-016 halt SHALL enter HALT after T2.
REQ-017 In HALT, run=0, all other outputs SHALL be 0, and the FSM SHALL leave HALT only on clr.
REQ-018 The stop request SHALL be latched in a sticky flag, cleared on entry to T0.
REQ-019 The FSM SHALL never assert more than one bus-source select, or read and write together, in the same cycle.

Reset
REQ-020 clr=1 at a clk edge SHALL force state RST from any state, including mid-instruction and HALT, aborting the instruction without completing any remaining step.
REQ-021 In RST, all outputs SHALL be 0 and run=1.
REQ-022 RST SHALL go to T0 on the first edge with clr=0, and the stop flag SHALL clear.

Structure
REQ-023 Opcode constants, state encoding and ALU-op index SHALL reside in shared package cpu_pkg.
REQ-024 One sub-module, instr_class_decode, SHALL map the opcode to an instruction class (rtype, imm, muldiv, ld, ldi, st, br, unary, single, jal, halt) and to the ALU op.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then a fetch with ir=add R1,R2,R3 (0x18918000): T0–T5 assert exactly the REQ-003/REQ-005 signals, then return to T0.
- br with con=0 vs con=1: PCIn asserted in T6 only when con=1.
- mul: LoIn in T5, HiIn in T6, next state T0.
- stop pulsed in T4 of ld: T7 completes, then HALT with run=0.
- clr asserted in T6 of st: write is never asserted, next state RST, then T0.
- opcode 30: behaves as nop, with no enables in T3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer states, ALU op indices.
// Also holds the instruction class and control-word bundle types.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_e;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam int ALU_W   = 12;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_DIV = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_OR  = 5;
  localparam int ALU_SHR = 6;
  localparam int ALU_SHL = 7;
  localparam int ALU_ROR = 8;
  localparam int ALU_ROL = 9;
  localparam int ALU_NEG = 10;
  localparam int ALU_NOT = 11;

  typedef logic [ALU_W-1:0] alu_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_IMM,
    C_MULDIV,
    C_LD,
    C_LDI,
    C_ST,
    C_BR,
    C_UNARY,
    C_SINGLE,
    C_JAL,
    C_HALT
  } iclass_e;

  typedef struct packed {
    logic pcout;
    logic zlowout;
    logic zhighout;
    logic mdrout;
    logic cout;
    logic inportout;
    logic loout;
    logic hiout;
    logic marin;
    logic pcin;
    logic mdrin;
    logic irin;
    logic yin;
    logic incpc;
    logic hiin;
    logic loin;
    logic inin;
    logic outin;
    logic zin;
    logic conin;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baout;
    logic read;
    logic write;
    alu_t alu;
  } ctrl_t;

  function automatic alu_t alu_onehot(input int idx);
    return alu_t'(1) << idx;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Maps opcode to an instruction class and its one-hot ALU op.
// Ports: op_i opcode in; cls_o class out; alu_o one-hot ALU op out.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0] op_i,
  output iclass_e    cls_o,
  output alu_t       alu_o
);

  always_comb begin
    cls_o = C_SINGLE;
    alu_o = '0;
    unique case (op_i)
      OP_LD:   begin cls_o = C_LD;  alu_o = alu_onehot(ALU_ADD); end
      OP_LDI:  begin cls_o = C_LDI; alu_o = alu_onehot(ALU_ADD); end
      OP_ST:   begin cls_o = C_ST;  alu_o = alu_onehot(ALU_ADD); end
      OP_ADD:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_ADD); end
      OP_SUB:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_SUB); end
      OP_AND:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_AND); end
      OP_OR:   begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_OR);  end
      OP_SHR:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_SHR); end
      OP_SHL:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_SHL); end
      OP_ROR:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_ROR); end
      OP_ROL:  begin cls_o = C_RTYPE; alu_o = alu_onehot(ALU_ROL); end
      OP_ADDI: begin cls_o = C_IMM; alu_o = alu_onehot(ALU_ADD); end
      OP_ANDI: begin cls_o = C_IMM; alu_o = alu_onehot(ALU_AND); end
      OP_ORI:  begin cls_o = C_IMM; alu_o = alu_onehot(ALU_OR);  end
      OP_MUL:  begin cls_o = C_MULDIV; alu_o = alu_onehot(ALU_MUL); end
      OP_DIV:  begin cls_o = C_MULDIV; alu_o = alu_onehot(ALU_DIV); end
      OP_NEG:  begin cls_o = C_UNARY; alu_o = alu_onehot(ALU_NEG); end
      OP_NOT:  begin cls_o = C_UNARY; alu_o = alu_onehot(ALU_NOT); end
      OP_BR:   begin cls_o = C_BR;  alu_o = alu_onehot(ALU_ADD); end
      OP_JAL:  cls_o = C_JAL;
      OP_HALT: cls_o = C_HALT;
      // jr/in/out/mfhi/mflo/nop and unused codes 27-31
      default: cls_o = C_SINGLE;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch, T3-T7 execute, halt.
// Ports: clk/clr, ir/con/stop in; run + bus/enable/ALU controls out.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        In_Portout,
  output logic        LOout,
  output logic        HIout,
  output logic        MARIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        IRIn,
  output logic        YIn,
  output logic        IncPC,
  output logic        HiIn,
  output logic        LoIn,
  output logic        InIn,
  output logic        OutIn,
  output logic        ZIn,
  output logic        CONIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        read,
  output logic        write,
  output logic        add,
  output logic        subtract,
  output logic        multiply,
  output logic        divide,
  output logic        andSignal,
  output logic        orSignal,
  output logic        shrSignal,
  output logic        ShlSignal,
  output logic        RorSignal,
  output logic        RolSignal,
  output logic        NegSignal,
  output logic        NotSignal
);

  state_e  state_q, state_d;
  logic    stop_q, stop_d;
  iclass_e cls;
  alu_t    alu;
  ctrl_t   c;
  logic    last;
  logic [4:0] op;

  assign op = ir[31:27];

  instr_class_decode u_dec (
    .op_i  (op),
    .cls_o (cls),
    .alu_o (alu)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RST;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    unique case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = (cls == C_HALT) ? S_HALT : S_T3;
      S_T3:
        if (cls == C_SINGLE) last = 1'b1;
        else state_d = S_T4;
      S_T4:
        if (cls inside {C_UNARY, C_JAL}) last = 1'b1;
        else state_d = S_T5;
      S_T5:
        if (cls inside {C_RTYPE, C_IMM, C_LDI}) last = 1'b1;
        else state_d = S_T6;
      S_T6:
        if (cls inside {C_MULDIV, C_BR}) last = 1'b1;
        else state_d = S_T7;
      S_T7:   last = 1'b1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    // stop raised on the final step itself still counts
    if (last) state_d = (stop_q | stop) ? S_HALT : S_T0;
    stop_d = (state_d == S_T0) ? 1'b0 : (stop_q | stop);
  end

  always_comb begin
    c = '0;
    unique case (state_q)
      S_T0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; end
      S_T1: begin c.read = 1'b1; c.mdrin = 1'b1; end
      S_T2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      S_T3:
        unique case (cls)
          C_RTYPE, C_IMM: begin
            c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1;
          end
          C_MULDIV: begin
            c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1;
          end
          C_BR: begin
            c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1;
          end
          C_UNARY: begin
            c.grb = 1'b1; c.rout = 1'b1;
            c.alu = alu; c.zin = 1'b1;
          end
          C_JAL: begin
            c.pcout = 1'b1; c.grb = 1'b1; c.rin = 1'b1;
          end
          C_SINGLE:
            unique case (op)
              OP_JR: begin
                c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1;
              end
              OP_IN: begin
                c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
              end
              OP_OUT: begin
                c.gra = 1'b1; c.rout = 1'b1; c.outin = 1'b1;
              end
              OP_MFHI: begin
                c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
              end
              OP_MFLO: begin
                c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
              end
              default: c = '0;
            endcase
          default: c = '0;
        endcase
      S_T4:
        unique case (cls)
          C_RTYPE: begin
            c.grc = 1'b1; c.rout = 1'b1;
            c.alu = alu; c.zin = 1'b1;
          end
          C_IMM: begin
            c.cout = 1'b1; c.alu = alu; c.zin = 1'b1;
          end
          C_MULDIV: begin
            c.grb = 1'b1; c.rout = 1'b1;
            c.alu = alu; c.zin = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            c.cout = 1'b1; c.zin = 1'b1;
            c.alu = alu_onehot(ALU_ADD);
          end
          C_BR: begin c.pcout = 1'b1; c.yin = 1'b1; end
          C_UNARY: begin
            c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
          end
          C_JAL: begin
            c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1;
          end
          default: c = '0;
        endcase
      S_T5:
        unique case (cls)
          C_RTYPE, C_IMM, C_LDI: begin
            c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
          end
          C_MULDIV: begin c.zlowout = 1'b1; c.loin = 1'b1; end
          C_LD, C_ST: begin c.zlowout = 1'b1; c.marin = 1'b1; end
          C_BR: begin
            c.cout = 1'b1; c.zin = 1'b1;
            c.alu = alu_onehot(ALU_ADD);
          end
          default: c = '0;
        endcase
      S_T6:
        unique case (cls)
          C_MULDIV: begin c.zhighout = 1'b1; c.hiin = 1'b1; end
          C_LD: begin c.read = 1'b1; c.mdrin = 1'b1; end
          C_ST: begin
            c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1;
          end
          C_BR: begin c.zlowout = con; c.pcin = con; end
          default: c = '0;
        endcase
      S_T7:
        unique case (cls)
          C_LD: begin
            c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1;
          end
          C_ST: c.write = 1'b1;
          default: c = '0;
        endcase
      default: c = '0;
    endcase
  end

  assign run        = (state_q != S_HALT);
  assign PCout      = c.pcout;
  assign Zlowout    = c.zlowout;
  assign Zhighout   = c.zhighout;
  assign MDRout     = c.mdrout;
  assign Cout       = c.cout;
  assign In_Portout = c.inportout;
  assign LOout      = c.loout;
  assign HIout      = c.hiout;
  assign MARIn      = c.marin;
  assign PCIn       = c.pcin;
  assign MDRIn      = c.mdrin;
  assign IRIn       = c.irin;
  assign YIn        = c.yin;
  assign IncPC      = c.incpc;
  assign HiIn       = c.hiin;
  assign LoIn       = c.loin;
  assign InIn       = c.inin;
  assign OutIn      = c.outin;
  assign ZIn        = c.zin;
  assign CONIn      = c.conin;
  assign Gra        = c.gra;
  assign Grb        = c.grb;
  assign Grc        = c.grc;
  assign Rin        = c.rin;
  assign Rout       = c.rout;
  assign BAout      = c.baout;
  assign read       = c.read;
  assign write      = c.write;
  assign add        = c.alu[ALU_ADD];
  assign subtract   = c.alu[ALU_SUB];
  assign multiply   = c.alu[ALU_MUL];
  assign divide     = c.alu[ALU_DIV];
  assign andSignal  = c.alu[ALU_AND];
  assign orSignal   = c.alu[ALU_OR];
  assign shrSignal  = c.alu[ALU_SHR];
  assign ShlSignal  = c.alu[ALU_SHL];
  assign RorSignal  = c.alu[ALU_ROR];
  assign RolSignal  = c.alu[ALU_ROL];
  assign NegSignal  = c.alu[ALU_NEG];
  assign NotSignal  = c.alu[ALU_NOT];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer.
// Each row is one clock cycle: inputs plus the full expected output word.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [31:0] ir = '0;
  logic con = 1'b0;
  logic stop = 1'b0;

  logic run, PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout;
  logic LOout, HIout, MARIn, PCIn, MDRIn, IRIn, YIn, IncPC;
  logic HiIn, LoIn, InIn, OutIn, ZIn, CONIn, Gra, Grb, Grc;
  logic Rin, Rout, BAout, read, write, add, subtract, multiply;
  logic divide, andSignal, orSignal, shrSignal, ShlSignal;
  logic RorSignal, RolSignal, NegSignal, NotSignal;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con), .stop(stop),
    .run(run), .PCout(PCout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .In_Portout(In_Portout), .LOout(LOout), .HIout(HIout),
    .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn),
    .YIn(YIn), .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn),
    .InIn(InIn), .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .read(read), .write(write), .add(add),
    .subtract(subtract), .multiply(multiply), .divide(divide),
    .andSignal(andSignal), .orSignal(orSignal),
    .shrSignal(shrSignal), .ShlSignal(ShlSignal),
    .RorSignal(RorSignal), .RolSignal(RolSignal),
    .NegSignal(NegSignal), .NotSignal(NotSignal)
  );

  logic [40:0] act;
  assign act = {NotSignal, NegSignal, RolSignal, RorSignal,
                ShlSignal, shrSignal, orSignal, andSignal,
                divide, multiply, subtract, add, write, read,
                BAout, Rout, Rin, Grc, Grb, Gra, CONIn, ZIn,
                OutIn, InIn, LoIn, HiIn, IncPC, YIn, IRIn,
                MDRIn, PCIn, MARIn, HIout, LOout, In_Portout,
                Cout, MDRout, Zhighout, Zlowout, PCout, run};

  localparam logic [40:0] B_RUN   = 41'h1 << 0;
  localparam logic [40:0] B_PCO   = 41'h1 << 1;
  localparam logic [40:0] B_ZLO   = 41'h1 << 2;
  localparam logic [40:0] B_ZHI   = 41'h1 << 3;
  localparam logic [40:0] B_MDRO  = 41'h1 << 4;
  localparam logic [40:0] B_CO    = 41'h1 << 5;
  localparam logic [40:0] B_MARI  = 41'h1 << 9;
  localparam logic [40:0] B_PCI   = 41'h1 << 10;
  localparam logic [40:0] B_MDRI  = 41'h1 << 11;
  localparam logic [40:0] B_IRI   = 41'h1 << 12;
  localparam logic [40:0] B_YI    = 41'h1 << 13;
  localparam logic [40:0] B_INC   = 41'h1 << 14;
  localparam logic [40:0] B_HII   = 41'h1 << 15;
  localparam logic [40:0] B_LOI   = 41'h1 << 16;
  localparam logic [40:0] B_ZI    = 41'h1 << 19;
  localparam logic [40:0] B_CONI  = 41'h1 << 20;
  localparam logic [40:0] B_GRA   = 41'h1 << 21;
  localparam logic [40:0] B_GRB   = 41'h1 << 22;
  localparam logic [40:0] B_GRC   = 41'h1 << 23;
  localparam logic [40:0] B_RIN   = 41'h1 << 24;
  localparam logic [40:0] B_ROUT  = 41'h1 << 25;
  localparam logic [40:0] B_BAO   = 41'h1 << 26;
  localparam logic [40:0] B_RD    = 41'h1 << 27;
  localparam logic [40:0] B_ADD   = 41'h1 << 29;
  localparam logic [40:0] B_MUL   = 41'h1 << 31;

  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_BR   = 32'h90800000;
  localparam logic [31:0] IR_MUL  = 32'h70880000;
  localparam logic [31:0] IR_30   = 32'hF0000000;
  localparam logic [31:0] IR_LD   = 32'h00900010;
  localparam logic [31:0] IR_ST   = 32'h10900010;
  localparam logic [31:0] IR_HALT = 32'hD0000000;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        con;
    logic        stop;
    logic [40:0] exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic v(input logic c, input logic [31:0] i,
                   input logic k, input logic s,
                   input logic [40:0] e);
    vec_t r;
    r.clr = c; r.ir = i; r.con = k; r.stop = s; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic fetch(input logic [31:0] i);
    v(0, i, 0, 0, B_RUN | B_PCO | B_MARI | B_INC);
    v(0, i, 0, 0, B_RUN | B_RD | B_MDRI);
    v(0, i, 0, 0, B_RUN | B_MDRO | B_IRI);
  endtask

  task automatic apply(input vec_t r, input string tag);
    clr = r.clr; ir = r.ir; con = r.con; stop = r.stop;
    #1;
    checks++;
    if (act !== r.exp) begin
      errors++;
      $display("FAIL %s outputs=%h want=%h", tag, act, r.exp);
    end
    checks++;
    if ($countones(act[8:1]) > 1 || (read && write)) begin
      errors++;
      $display("FAIL %s exclusive buses=%b rw=%b%b want<=1 src",
               tag, act[8:1], read, write);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t r;
    // reset and the add R1,R2,R3 walk-through
    v(1, IR_ADD, 0, 0, B_RUN);
    v(0, IR_ADD, 0, 0, B_RUN);
    fetch(IR_ADD);
    v(0, IR_ADD, 0, 0, B_RUN | B_GRB | B_ROUT | B_YI);
    v(0, IR_ADD, 0, 0, B_RUN | B_GRC | B_ROUT | B_ADD | B_ZI);
    v(0, IR_ADD, 0, 0, B_RUN | B_ZLO | B_GRA | B_RIN);
    // br not taken
    fetch(IR_BR);
    v(0, IR_BR, 0, 0, B_RUN | B_GRA | B_ROUT | B_CONI);
    v(0, IR_BR, 0, 0, B_RUN | B_PCO | B_YI);
    v(0, IR_BR, 0, 0, B_RUN | B_CO | B_ADD | B_ZI);
    v(0, IR_BR, 0, 0, B_RUN);
    // br taken
    fetch(IR_BR);
    v(0, IR_BR, 1, 0, B_RUN | B_GRA | B_ROUT | B_CONI);
    v(0, IR_BR, 1, 0, B_RUN | B_PCO | B_YI);
    v(0, IR_BR, 1, 0, B_RUN | B_CO | B_ADD | B_ZI);
    v(0, IR_BR, 1, 0, B_RUN | B_ZLO | B_PCI);
    // mul
    fetch(IR_MUL);
    v(0, IR_MUL, 0, 0, B_RUN | B_GRA | B_ROUT | B_YI);
    v(0, IR_MUL, 0, 0, B_RUN | B_GRB | B_ROUT | B_MUL | B_ZI);
    v(0, IR_MUL, 0, 0, B_RUN | B_ZLO | B_LOI);
    v(0, IR_MUL, 0, 0, B_RUN | B_ZHI | B_HII);
    // unused opcode 30 acts as nop
    fetch(IR_30);
    v(0, IR_30, 0, 0, B_RUN);
    // ld with stop pulsed in T4
    fetch(IR_LD);
    v(0, IR_LD, 0, 0, B_RUN | B_GRB | B_BAO | B_YI);
    v(0, IR_LD, 0, 1, B_RUN | B_CO | B_ADD | B_ZI);
    v(0, IR_LD, 0, 0, B_RUN | B_ZLO | B_MARI);
    v(0, IR_LD, 0, 0, B_RUN | B_RD | B_MDRI);
    v(0, IR_LD, 0, 0, B_RUN | B_MDRO | B_GRA | B_RIN);
    v(0, IR_ADD, 0, 0, '0);
    v(0, IR_ADD, 0, 0, '0);
    v(1, IR_ADD, 0, 0, '0);
    v(0, IR_ST, 0, 0, B_RUN);
    // st aborted by clr in T6
    fetch(IR_ST);
    v(0, IR_ST, 0, 0, B_RUN | B_GRB | B_BAO | B_YI);
    v(0, IR_ST, 0, 0, B_RUN | B_CO | B_ADD | B_ZI);
    v(0, IR_ST, 0, 0, B_RUN | B_ZLO | B_MARI);
    v(1, IR_ST, 0, 0, B_RUN | B_GRA | B_ROUT | B_MDRI);
    v(0, IR_ST, 0, 0, B_RUN);
    v(0, IR_ST, 0, 0, B_RUN | B_PCO | B_MARI | B_INC);

    clr = 1'b1;
    repeat (2) @(negedge clk);
    foreach (tbl[n]) apply(tbl[n], $sformatf("vec[%0d]", n));

    // halt opcode: from T1 onward, HALT after T2, sticky until clr
    r.clr = 0; r.ir = IR_HALT; r.con = 0; r.stop = 0;
    r.exp = B_RUN | B_RD | B_MDRI;
    apply(r, "halt_t1");
    r.exp = B_RUN | B_MDRO | B_IRI;
    apply(r, "halt_t2");
    r.exp = '0;
    for (int k = 0; k < 3; k++) apply(r, $sformatf("halt_hold%0d", k));
    r.clr = 1;
    apply(r, "halt_clr");
    r.clr = 0; r.exp = B_RUN;
    apply(r, "halt_rst");
    r.exp = B_RUN | B_PCO | B_MARI | B_INC;
    apply(r, "halt_t0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
